// File: rtl/risc_data_mem_arbiter.sv
// Data-memory arbiter for two requesters: the CPU (port A, fixed priority) and the loader/debug DMA (port B).
// Port B is protected by a starvation counter. Responses are registered with 1-cycle latency.
module risc_data_mem_arbiter #(
    parameter int DEPTH    = 1024,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_stall,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    output logic        a_err,

    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic        b_err,

    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,

    output logic [15:0] conflict_cnt
);

    localparam logic [3:0]  MAX_WAIT_W = 4'(MAX_WAIT);
    localparam logic [31:0] DEPTH_W    = 32'(DEPTH);

    logic [3:0]  wait_cnt_reg;
    logic [3:0]  wait_cnt_next;
    logic        last_winner_reg;   // 0: port A, 1: port B
    logic        resp_valid_reg;
    logic        resp_err_reg;
    logic [15:0] conflict_cnt_reg;
    logic [31:0] addr_hold_reg;
    logic [31:0] wdata_hold_reg;
    logic [31:0] rdata_reg [2];

    logic        both_req;
    logic        b_forced;
    logic        a_win;
    logic        b_win;
    logic        any_gnt;
    logic        win_we;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic        in_range;
    logic [31:0] rdata_capture;
    logic [1:0]  gnt_vec;

    // Winner selection; reset low forces every grant off.
    always_comb begin
        both_req = a_req & b_req;
        b_forced = (wait_cnt_reg == MAX_WAIT_W);
        a_win    = a_req & (~b_req | ~b_forced);
        b_win    = b_req & (~a_req | b_forced);
        a_gnt    = a_win & reset;
        b_gnt    = b_win & reset;
        any_gnt  = a_gnt | b_gnt;
        a_stall  = a_req & ~a_gnt;
        gnt_vec  = {b_gnt, a_gnt};
    end

    always_comb begin
        win_we    = a_we;
        win_addr  = a_addr;
        win_wdata = a_wdata;
        if (b_gnt) begin
            win_we    = b_we;
            win_addr  = b_addr;
            win_wdata = b_wdata;
        end
        in_range = (win_addr < DEPTH_W);
    end

    // Idle cycles keep the bus steady at the last granted address and data.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = addr_hold_reg;
        mem_wdata = wdata_hold_reg;
        if (any_gnt) begin
            mem_we    = win_we & in_range;
            mem_addr  = win_addr;
            mem_wdata = win_wdata;
        end
    end

    always_comb begin
        rdata_capture = 32'd0;
        if (!win_we && in_range) begin
            rdata_capture = mem_rdata;
        end
    end

    always_comb begin
        wait_cnt_next = 4'd0;
        if (b_req && !b_gnt) begin
            wait_cnt_next = (wait_cnt_reg == MAX_WAIT_W) ? wait_cnt_reg : wait_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_reg     <= 4'd0;
            last_winner_reg  <= 1'b0;
            resp_valid_reg   <= 1'b0;
            resp_err_reg     <= 1'b0;
            conflict_cnt_reg <= 16'd0;
            addr_hold_reg    <= 32'd0;
            wdata_hold_reg   <= 32'd0;
        end else begin
            wait_cnt_reg   <= wait_cnt_next;
            resp_valid_reg <= any_gnt;
            resp_err_reg   <= any_gnt & ~in_range;
            if (any_gnt) begin
                last_winner_reg <= b_gnt;
                addr_hold_reg   <= win_addr;
                wdata_hold_reg  <= win_wdata;
            end
            if (both_req && conflict_cnt_reg != 16'hFFFF) begin
                conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
            end
        end
    end

    // Per-port read data holds its last value between responses.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rdata_reg[gi] <= 32'd0;
                end else if (gnt_vec[gi]) begin
                    rdata_reg[gi] <= rdata_capture;
                end
            end
        end
    endgenerate

    assign a_rvalid     = resp_valid_reg & ~last_winner_reg;
    assign b_rvalid     = resp_valid_reg &  last_winner_reg;
    assign a_err        = resp_err_reg   & ~last_winner_reg;
    assign b_err        = resp_err_reg   &  last_winner_reg;
    assign a_rdata      = rdata_reg[0];
    assign b_rdata      = rdata_reg[1];
    assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_risc_data_mem_arbiter.sv
// Directed testbench for risc_data_mem_arbiter with a behavioural 1024-word data memory.
module tb_risc_data_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_stall, a_rvalid, a_err;
    logic        b_gnt, b_rvalid, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] conflict_cnt;

    logic [31:0] mem [0:1023];

    int checks = 0;
    int passed = 0;

    risc_data_mem_arbiter #(.DEPTH(1024), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_stall(a_stall), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (mem_we && mem_addr < 32'd1024) mem[mem_addr[9:0]] <= mem_wdata;
    end
    assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'd0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'd3; a_wdata = 32'h11;
        b_req = 1'b1; b_we = 1'b1; b_addr = 32'd4; b_wdata = 32'h22;
        #2;
        checks++; if (a_gnt !== 1'b0) $display("FAIL reset_a_gnt: got %0h expected 0", a_gnt); else passed++;
        checks++; if (b_gnt !== 1'b0) $display("FAIL reset_b_gnt: got %0h expected 0", b_gnt); else passed++;
        checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %0h expected 0", mem_we); else passed++;
        checks++; if (a_stall !== 1'b1) $display("FAIL reset_a_stall: got %0h expected 1", a_stall); else passed++;
        checks++; if ({a_rvalid, a_err, b_rvalid, b_err} !== 4'b0)
            $display("FAIL reset_flags: got %b expected 0000", {a_rvalid, a_err, b_rvalid, b_err}); else passed++;
        checks++; if ({a_rdata, b_rdata} !== 64'd0)
            $display("FAIL reset_rdata: got %h expected 0", {a_rdata, b_rdata}); else passed++;
        tick();
        tick();
        checks++; if (conflict_cnt !== 16'd0) $display("FAIL reset_conflict_cnt: got %0d expected 0", conflict_cnt); else passed++;
        checks++; if (a_rvalid !== 1'b0) $display("FAIL reset_hold_a_rvalid: got %0h expected 0", a_rvalid); else passed++;
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_write_read_a();
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'd5; a_wdata = 32'hDEADBEEF;
        #1;
        checks++; if ({a_gnt, b_gnt, mem_we} !== 3'b101) $display("FAIL wr_a_grant: got %b expected 101", {a_gnt, b_gnt, mem_we}); else passed++;
        checks++; if (mem_addr !== 32'd5) $display("FAIL wr_a_mem_addr: got %0d expected 5", mem_addr); else passed++;
        tick();
        checks++; if ({a_rvalid, a_err} !== 2'b10) $display("FAIL wr_a_resp: got %b expected 10", {a_rvalid, a_err}); else passed++;
        checks++; if (a_rdata !== 32'd0) $display("FAIL wr_a_rdata: got %h expected 0", a_rdata); else passed++;
        a_we = 1'b0;
        #1;
        checks++; if ({a_gnt, mem_we} !== 2'b10) $display("FAIL rd_a_grant: got %b expected 10", {a_gnt, mem_we}); else passed++;
        tick();
        a_req = 1'b0; a_addr = 32'd77;
        checks++; if ({a_rvalid, a_err} !== 2'b10) $display("FAIL rd_a_resp: got %b expected 10", {a_rvalid, a_err}); else passed++;
        checks++; if (a_rdata !== 32'hDEADBEEF) $display("FAIL rd_a_rdata: got %h expected deadbeef", a_rdata); else passed++;
        checks++; if ({b_rvalid, b_err, b_rdata} !== 34'd0) $display("FAIL rd_a_b_quiet: got %h expected 0", {b_rvalid, b_err, b_rdata}); else passed++;
        #1;
        checks++; if (mem_addr !== 32'd5 || mem_we !== 1'b0)
            $display("FAIL idle_hold: got addr %0d we %0h expected addr 5 we 0", mem_addr, mem_we); else passed++;
        tick();
        checks++; if (a_rvalid !== 1'b0) $display("FAIL rd_a_rvalid_drop: got %0h expected 0", a_rvalid); else passed++;
        checks++; if (a_rdata !== 32'hDEADBEEF) $display("FAIL rd_a_rdata_hold: got %h expected deadbeef", a_rdata); else passed++;
    endtask

    task automatic test_out_of_range();
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'd0; a_wdata = 32'h0BADF00D;
        tick();
        a_addr = 32'd1023; a_wdata = 32'h55;
        #1;
        checks++; if (mem_we !== 1'b1) $display("FAIL top_addr_we: got %0h expected 1", mem_we); else passed++;
        tick();
        checks++; if (a_err !== 1'b0) $display("FAIL top_addr_err: got %0h expected 0", a_err); else passed++;
        a_req = 1'b0;
        b_req = 1'b1; b_we = 1'b1; b_addr = 32'd1024; b_wdata = 32'h1234;
        #1;
        checks++; if ({b_gnt, mem_we} !== 2'b10) $display("FAIL oor_b_grant: got %b expected 10", {b_gnt, mem_we}); else passed++;
        tick();
        b_req = 1'b0;
        checks++; if ({b_rvalid, b_err} !== 2'b11) $display("FAIL oor_b_resp: got %b expected 11", {b_rvalid, b_err}); else passed++;
        checks++; if (b_rdata !== 32'd0) $display("FAIL oor_b_rdata: got %h expected 0", b_rdata); else passed++;
        checks++; if (a_rvalid !== 1'b0) $display("FAIL oor_a_quiet: got %0h expected 0", a_rvalid); else passed++;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'd0;
        tick();
        a_addr = 32'hFFFF_FFFF;
        checks++; if (a_rdata !== 32'h0BADF00D) $display("FAIL oor_addr0_intact: got %h expected 0badf00d", a_rdata); else passed++;
        tick();
        a_req = 1'b0;
        checks++; if ({a_rvalid, a_err, a_rdata} !== {2'b11, 32'd0})
            $display("FAIL oor_a_read: got %b/%h expected 11/0", {a_rvalid, a_err}, a_rdata); else passed++;
        tick();
    endtask

    task automatic test_starvation();
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'd1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'd2;
        for (int k = 0; k < 10; k++) begin
            logic exp_b;
            exp_b = (k % 5 == 4);
            #1;
            checks++; if ({a_gnt, b_gnt, a_stall} !== {~exp_b, exp_b, exp_b})
                $display("FAIL starve_gnt_%0d: got %b expected %b", k, {a_gnt, b_gnt, a_stall}, {~exp_b, exp_b, exp_b}); else passed++;
            tick();
            checks++; if ({a_rvalid, b_rvalid} !== {~exp_b, exp_b})
                $display("FAIL starve_rvalid_%0d: got %b expected %b", k, {a_rvalid, b_rvalid}, {~exp_b, exp_b}); else passed++;
        end
        checks++; if (conflict_cnt !== 16'd10) $display("FAIL starve_conflict_cnt: got %0d expected 10", conflict_cnt); else passed++;
        a_req = 1'b0; b_req = 1'b0;
        tick();
    endtask

    task automatic test_contention_order();
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'd7; a_wdata = 32'hA;
        b_req = 1'b1; b_we = 1'b1; b_addr = 32'd7; b_wdata = 32'hB;
        #1;
        checks++; if ({a_gnt, b_gnt} !== 2'b10 || mem_wdata !== 32'hA)
            $display("FAIL order_first: got gnt %b wdata %h expected 10/a", {a_gnt, b_gnt}, mem_wdata); else passed++;
        tick();
        a_req = 1'b0;
        checks++; if (mem[7] !== 32'hA) $display("FAIL order_a_commit: got %h expected a", mem[7]); else passed++;
        #1;
        checks++; if ({a_gnt, b_gnt, mem_we} !== 3'b011 || mem_wdata !== 32'hB)
            $display("FAIL order_second: got gnt/we %b wdata %h expected 011/b", {a_gnt, b_gnt, mem_we}, mem_wdata); else passed++;
        tick();
        b_req = 1'b0;
        checks++; if (conflict_cnt !== 16'd11) $display("FAIL order_conflict_cnt: got %0d expected 11", conflict_cnt); else passed++;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'd7;
        tick();
        a_req = 1'b0;
        checks++; if (a_rdata !== 32'hB) $display("FAIL order_final_read: got %h expected b", a_rdata); else passed++;
        tick();
    endtask

    task automatic test_async_reset();
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'd5;
        b_req = 1'b1; b_we = 1'b1; b_addr = 32'd9; b_wdata = 32'h99;
        tick();
        checks++; if (a_rvalid !== 1'b1) $display("FAIL areset_pre_rvalid: got %0h expected 1", a_rvalid); else passed++;
        #2;
        reset = 1'b0;
        #1;
        checks++; if ({mem_we, a_gnt, b_gnt, a_rvalid} !== 4'b0)
            $display("FAIL areset_outputs: got %b expected 0000", {mem_we, a_gnt, b_gnt, a_rvalid}); else passed++;
        checks++; if (conflict_cnt !== 16'd0) $display("FAIL areset_conflict_cnt: got %0d expected 0", conflict_cnt); else passed++;
        a_req = 1'b0; b_req = 1'b0;
        tick();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (a_rvalid !== 1'b0) $display("FAIL areset_no_pulse_%0d: got %0h expected 0", k, a_rvalid); else passed++;
        end
    endtask

    task automatic test_saturation();
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'd1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'd2;
        repeat (65534) @(posedge clk);
        #1;
        checks++; if (conflict_cnt !== 16'hFFFE) $display("FAIL sat_fffe: got %h expected fffe", conflict_cnt); else passed++;
        tick();
        checks++; if (conflict_cnt !== 16'hFFFF) $display("FAIL sat_ffff: got %h expected ffff", conflict_cnt); else passed++;
        repeat (4465) @(posedge clk);
        #1;
        checks++; if (conflict_cnt !== 16'hFFFF) $display("FAIL sat_no_wrap: got %h expected ffff", conflict_cnt); else passed++;
        a_req = 1'b0; b_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read_a();
        test_out_of_range();
        test_starvation();
        test_contention_order();
        test_async_reset();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
